bitty_prog_loader: RTL and testbench

//   Byte-serial program loader for the Bitty core's instruction memory (upstream of memory/pc/bitty).

---
 rtl/bitty_prog_loader.sv | 153 +++++++++++++++
 tb/tb_bitty_prog_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitty_prog_loader.sv
// Byte-serial program loader for the Bitty instruction memory.
// Frame: count, count x {hi, lo} words, then 8-bit additive checksum.
module bitty_prog_loader #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] BASE =
      ADDR_W'(BASE_ADDR);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_HI,
      S_LO,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [7:0]        sum;
   logic [7:0]        sum_nx;
   logic [7:0]        remaining;
   logic [7:0]        remaining_nx;
   logic [7:0]        hi;
   logic [7:0]        hi_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [DATA_W-1:0] wdata_nx;
   logic              xfer;

   // Outputs decode straight from the state register.
   assign byte_ready = (state == S_COUNT) ||
                       (state == S_HI)    ||
                       (state == S_LO)    ||
                       (state == S_CHECK);
   assign mem_we     = (state == S_WRITE);
   assign cpu_hold   = byte_ready || mem_we;
   assign load_done  = (state == S_DONE);
   assign err        = (state == S_ERR);

   assign xfer = byte_valid & byte_ready;

   always_comb begin
      state_nx     = state;
      sum_nx       = sum;
      remaining_nx = remaining;
      hi_nx        = hi;
      addr_nx      = mem_addr;
      wdata_nx     = mem_wdata;
      unique case (state)
         S_IDLE: begin
            if (load_en) begin
               state_nx = S_COUNT;
               addr_nx  = BASE;
               sum_nx   = 8'd0;
            end
         end
         S_COUNT: begin
            if (!load_en) begin
               state_nx = S_IDLE;
            end else if (xfer) begin
               if (byte_in == 8'd0) begin
                  state_nx = S_ERR;
               end else begin
                  remaining_nx = byte_in;
                  sum_nx       = byte_in;
                  state_nx     = S_HI;
               end
            end
         end
         S_HI: begin
            if (!load_en) begin
               state_nx = S_IDLE;
            end else if (xfer) begin
               hi_nx    = byte_in;
               sum_nx   = sum + byte_in;
               state_nx = S_LO;
            end
         end
         S_LO: begin
            if (!load_en) begin
               state_nx = S_IDLE;
            end else if (xfer) begin
               wdata_nx = DATA_W'({hi, byte_in});
               sum_nx   = sum + byte_in;
               state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            // The strobe for this word is already out; an abort
            // only decides where we go afterwards.
            addr_nx      = mem_addr + 1'b1;
            remaining_nx = remaining - 8'd1;
            if (!load_en) begin
               state_nx = S_IDLE;
            end else if (remaining == 8'd1) begin
               state_nx = S_CHECK;
            end else begin
               state_nx = S_HI;
            end
         end
         S_CHECK: begin
            if (!load_en) begin
               state_nx = S_IDLE;
            end else if (xfer) begin
               state_nx = (byte_in == sum) ? S_DONE : S_ERR;
            end
         end
         S_DONE, S_ERR: begin
            if (!load_en) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         sum       <= 8'd0;
         remaining <= 8'd0;
         hi        <= 8'd0;
         mem_addr  <= BASE;
         mem_wdata <= '0;
      end else begin
         state     <= state_nx;
         sum       <= sum_nx;
         remaining <= remaining_nx;
         hi        <= hi_nx;
         mem_addr  <= addr_nx;
         mem_wdata <= wdata_nx;
      end
   end

endmodule

// File: tb/tb_bitty_prog_loader.sv
// Bench for bitty_prog_loader: table vectors, random frames and
// hand-written reset sequence, checked against a frame-level model.
module tb_bitty_prog_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_en = 1'b0;
   logic [7:0] byte_in = 8'd0;
   logic       byte_valid = 1'b0;

   logic        ready0, we0, hold0, done0, err0;
   logic [7:0]  addr0;
   logic [15:0] wd0;
   logic        ready1, we1, hold1, done1, err1;
   logic [7:0]  addr1;
   logic [15:0] wd1;

   int total = 0;
   int bad = 0;

   logic [23:0] wq0[$];
   logic [23:0] wq1[$];

   typedef struct {
      string       name;
      logic [127:0] b;
      int          len;
      int          abort_at;
      bit          rnd;
      bit          xdone;
      bit          xerr;
   } vec_t;

   vec_t tab[6];

   always #5 clk = ~clk;

   bitty_prog_loader #(
      .ADDR_W(8), .DATA_W(16), .BASE_ADDR(0)
   ) u0 (
      .clk(clk), .rst_n(rst_n), .load_en(load_en),
      .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(ready0), .mem_we(we0),
      .mem_addr(addr0), .mem_wdata(wd0),
      .cpu_hold(hold0), .load_done(done0), .err(err0)
   );

   bitty_prog_loader #(
      .ADDR_W(8), .DATA_W(16), .BASE_ADDR(255)
   ) u1 (
      .clk(clk), .rst_n(rst_n), .load_en(load_en),
      .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(ready1), .mem_we(we1),
      .mem_addr(addr1), .mem_wdata(wd1),
      .cpu_hold(hold1), .load_done(done1), .err(err1)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (we0) begin
         wq0.push_back({addr0, wd0});
         chk("ready_in_write", 32'(ready0), 32'd0);
      end
      if (we1) wq1.push_back({addr1, wd1});
   end

   function automatic logic [7:0] bt(input vec_t v, input int i);
      return v.b[127-8*i -: 8];
   endfunction

   task automatic send(input logic [7:0] b, input bit rnd);
      bit taken = 1'b0;
      int t = 0;
      while (!taken) begin
         @(negedge clk);
         byte_in = b;
         byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (byte_valid && ready0) taken = 1'b1;
         t++;
         if (!taken && t > 200) begin
            chk("send_timeout", 32'd1, 32'd0);
            taken = 1'b1;
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      int n, sent, nw, pairs;
      logic [7:0] a;
      logic [15:0] w;
      n = int'(bt(v, 0));
      sent = (v.abort_at >= 0) ? v.abort_at : v.len;
      pairs = (sent - 1) / 2;
      nw = (n == 0) ? 0 : ((pairs < n) ? pairs : n);
      wq0.delete();
      wq1.delete();
      load_en = 1'b1;
      for (int i = 0; i < sent; i++) send(bt(v, i), v.rnd);
      @(negedge clk);
      byte_valid = 1'b0;
      if (v.abort_at < 0) begin
         chk({v.name, "_done"}, 32'(done0), 32'(v.xdone));
         chk({v.name, "_err"}, 32'(err0), 32'(v.xerr));
         chk({v.name, "_hold"}, 32'(hold0), 32'd0);
         chk({v.name, "_done1"}, 32'(done1), 32'(v.xdone));
         chk({v.name, "_err1"}, 32'(err1), 32'(v.xerr));
         repeat (3) @(negedge clk);
         chk({v.name, "_done_held"}, 32'(done0), 32'(v.xdone));
         chk({v.name, "_err_held"}, 32'(err0), 32'(v.xerr));
      end
      load_en = 1'b0;
      @(negedge clk);
      chk({v.name, "_idle_hold"}, 32'(hold0), 32'd0);
      chk({v.name, "_idle_done"}, 32'(done0), 32'd0);
      chk({v.name, "_idle_err"}, 32'(err0), 32'd0);
      chk({v.name, "_idle_ready"}, 32'(ready0), 32'd0);
      chk({v.name, "_idle_hold1"}, 32'(hold1), 32'd0);
      chk({v.name, "_nwrites"}, 32'(wq0.size()), 32'(nw));
      chk({v.name, "_nwrites1"}, 32'(wq1.size()), 32'(nw));
      for (int k = 0; k < nw; k++) begin
         w = {bt(v, 1 + 2*k), bt(v, 2 + 2*k)};
         a = 8'(k);
         if (k < wq0.size())
            chk({v.name, "_wr0"}, 32'(wq0[k]), 32'({a, w}));
         a = 8'(255 + k);
         if (k < wq1.size())
            chk({v.name, "_wr1"}, 32'(wq1[k]), 32'({a, w}));
      end
   endtask

   initial begin
      vec_t v;
      int n;
      logic [7:0] s, d, ck;
      bit corrupt;

      tab[0] = '{name:"load_ok",
                 b:{48'h021234ABCDC0, 80'h0},
                 len:6, abort_at:-1, rnd:0, xdone:1, xerr:0};
      tab[1] = '{name:"bad_sum",
                 b:{48'h021234ABCDC1, 80'h0},
                 len:6, abort_at:-1, rnd:0, xdone:0, xerr:1};
      tab[2] = '{name:"cnt_zero",
                 b:{8'h00, 120'h0},
                 len:1, abort_at:-1, rnd:0, xdone:0, xerr:1};
      tab[3] = '{name:"rnd_valid",
                 b:{48'h021234ABCDC0, 80'h0},
                 len:6, abort_at:-1, rnd:1, xdone:1, xerr:0};
      tab[4] = '{name:"abort",
                 b:{48'h021234ABCDC0, 80'h0},
                 len:6, abort_at:3, rnd:0, xdone:0, xerr:0};
      tab[5] = '{name:"one_word",
                 b:{32'h01BEEFAE, 96'h0},
                 len:4, abort_at:-1, rnd:1, xdone:1, xerr:0};

      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready0), 32'd0);
      chk("rst_we", 32'(we0), 32'd0);
      chk("rst_addr0", 32'(addr0), 32'h00);
      chk("rst_addr1", 32'(addr1), 32'hFF);
      chk("rst_wdata", 32'(wd0), 32'd0);
      chk("rst_hold", 32'(hold0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_err", 32'(err0), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(tab[i]);

      // Reset while sitting in LO of the second word.
      wq0.delete();
      wq1.delete();
      load_en = 1'b1;
      send(8'h02, 1'b0);
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      send(8'hAB, 1'b0);
      @(negedge clk);
      chk("pre_rst_hold", 32'(hold0), 32'd1);
      byte_in = 8'hCD;
      byte_valid = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_we", 32'(we0), 32'd0);
      chk("mid_rst_ready", 32'(ready0), 32'd0);
      chk("mid_rst_hold", 32'(hold0), 32'd0);
      chk("mid_rst_addr0", 32'(addr0), 32'h00);
      chk("mid_rst_addr1", 32'(addr1), 32'hFF);
      chk("mid_rst_wdata", 32'(wd0), 32'd0);
      chk("mid_rst_done", 32'(done0), 32'd0);
      chk("mid_rst_err", 32'(err0), 32'd0);
      byte_valid = 1'b0;
      load_en = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_nwrites", 32'(wq0.size()), 32'd1);
      run_vec(tab[0]);

      for (int r = 0; r < 20; r++) begin
         n = $urandom_range(1, 4);
         v.name = "rand";
         v.b = '0;
         v.len = 2 * n + 2;
         v.rnd = 1'b1;
         s = 8'(n);
         v.b[127 -: 8] = 8'(n);
         for (int i = 1; i <= 2 * n; i++) begin
            d = 8'($urandom_range(0, 255));
            v.b[127-8*i -: 8] = d;
            s = s + d;
         end
         corrupt = ($urandom_range(0, 3) == 0);
         ck = corrupt ? s ^ 8'($urandom_range(1, 255)) : s;
         v.b[127-8*(2*n+1) -: 8] = ck;
         v.xdone = !corrupt;
         v.xerr = corrupt;
         v.abort_at = -1;
         if ($urandom_range(0, 4) == 0) begin
            v.abort_at = $urandom_range(1, v.len - 1);
            v.xdone = 1'b0;
            v.xerr = 1'b0;
         end
         run_vec(v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
